// File: rtl/timer_preset_entry.sv
// Keypad front end for the microwave timer: collects BCD MM:SS digits and loads the counter chain.
// Optional build macro TIMER_ENTRY_NORMALIZE_EN folds seconds >= 60 into minutes on start.
module timer_preset_entry #(
    parameter int LOAD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        start,
    input  logic        clear_entry,
    input  logic        run_busy,
    output logic [15:0] digits,
    output logic        loadn,
    output logic [2:0]  digit_cnt,
    output logic        armed,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        LOAD   = 3'd2,
        ARMED  = 3'd3,
        LOCKED = 3'd4
    } state_t;

    localparam logic [2:0] LC = 3'(LOAD_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_digits, w_digits_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [2:0]  r_ctr, w_ctr_nxt;
    logic        r_loadn, w_loadn_nxt;
    logic        r_armed;
    logic        r_err, w_err_nxt;
    logic        w_sec_bad;

    assign w_cnt_inc = (r_cnt >= 3'd4) ? 3'd4 : r_cnt + 3'd1;
    assign w_sec_bad = (r_digits[7:4] >= 4'd6);

`ifdef TIMER_ENTRY_NORMALIZE_EN
    logic [15:0] w_norm;
    always_comb begin
        w_norm = r_digits;
        if (r_digits[15:12] == 4'd9 && r_digits[11:8] == 4'd9)
            w_norm = 16'h9959;
        else if (r_digits[11:8] == 4'd9)
            w_norm = {r_digits[15:12] + 4'd1, 4'd0, r_digits[7:4] - 4'd6, r_digits[3:0]};
        else
            w_norm = {r_digits[15:12], r_digits[11:8] + 4'd1, r_digits[7:4] - 4'd6, r_digits[3:0]};
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_cnt_nxt    = r_cnt;
        w_ctr_nxt    = r_ctr;
        w_loadn_nxt  = 1'b1;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE, ENTRY: begin
                if (clear_entry) begin
                    w_state_nxt  = IDLE;
                    w_digits_nxt = 16'h0000;
                    w_cnt_nxt    = 3'd0;
                end else if (start) begin
                    if (r_state == ENTRY) begin
                        if (w_sec_bad) begin
`ifdef TIMER_ENTRY_NORMALIZE_EN
                            w_digits_nxt = w_norm;
                            w_state_nxt  = LOAD;
                            w_ctr_nxt    = 3'd0;
`else
                            w_err_nxt    = 1'b1;
`endif
                        end else begin
                            w_state_nxt = LOAD;
                            w_ctr_nxt   = 3'd0;
                        end
                    end
                end else if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        w_digits_nxt = {r_digits[11:0], key_code};
                        w_cnt_nxt    = w_cnt_inc;
                        w_state_nxt  = ENTRY;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            // First LOAD cycle only settles digits; loadn drops on the following edge.
            LOAD: begin
                if (r_ctr == 3'd0) begin
                    w_loadn_nxt = 1'b0;
                    w_ctr_nxt   = 3'd1;
                end else if (r_ctr >= LC) begin
                    w_state_nxt = ARMED;
                end else begin
                    w_loadn_nxt = 1'b0;
                    w_ctr_nxt   = r_ctr + 3'd1;
                end
            end
            ARMED: begin
                if (run_busy) begin
                    w_state_nxt = LOCKED;
                end else if (clear_entry) begin
                    w_state_nxt  = IDLE;
                    w_digits_nxt = 16'h0000;
                    w_cnt_nxt    = 3'd0;
                end
            end
            LOCKED: begin
                if (!run_busy) begin
                    w_state_nxt  = IDLE;
                    w_digits_nxt = 16'h0000;
                    w_cnt_nxt    = 3'd0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state  <= IDLE;
            r_digits <= 16'h0000;
            r_cnt    <= 3'd0;
            r_ctr    <= 3'd0;
            r_loadn  <= 1'b1;
            r_armed  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_digits <= w_digits_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ctr    <= w_ctr_nxt;
            r_loadn  <= w_loadn_nxt;
            r_armed  <= (w_state_nxt == ARMED);
            r_err    <= w_err_nxt;
        end
    end

    assign digits    = r_digits;
    assign loadn     = r_loadn;
    assign digit_cnt = r_cnt;
    assign armed     = r_armed;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_timer_preset_entry.sv
// Self-checking bench for timer_preset_entry; every load pulse is checked against a queue of expected presets.
module tb_timer_preset_entry;

    localparam int LC = 1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_ARMED  = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        start = 1'b0;
    logic        clear_entry = 1'b0;
    logic        run_busy = 1'b0;
    logic [15:0] digits;
    logic        loadn;
    logic [2:0]  digit_cnt;
    logic        armed;
    logic        err;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic        prev_loadn = 1'b1;

    timer_preset_entry #(.LOAD_CYCLES(LC)) dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
        .start(start), .clear_entry(clear_entry), .run_busy(run_busy),
        .digits(digits), .loadn(loadn), .digit_cnt(digit_cnt), .armed(armed),
        .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: each falling edge of loadn must present the next expected preset.
    always @(negedge clk) begin
        if (prev_loadn === 1'b1 && loadn === 1'b0) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL load_unexpected: digits=%h, no load expected", digits);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (digits !== e) begin
                    bad = bad + 1;
                    $display("FAIL load_digits: got %h want %h", digits, e);
                end
            end
        end
        prev_loadn = loadn;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_entry = 1'b1;
        tick();
        clear_entry = 1'b0;
    endtask

    task automatic wait_armed(input string name);
        int n;
        n = 0;
        while (armed !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("FAIL %s_armed_timeout: armed=%b want 1", name, armed);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        key_valid = 1'b1;
        key_code = 4'd5;
        repeat (3) tick();
        total++;
        if ({digits, loadn, digit_cnt, armed, err, dbg_state} !== {16'h0000, 1'b1, 3'd0, 1'b0, 1'b0, S_IDLE}) begin
            bad++;
            $display("FAIL reset: digits=%h loadn=%b cnt=%0d armed=%b err=%b st=%0d", digits, loadn, digit_cnt, armed, err, dbg_state);
        end
        key_valid = 1'b0;
        clrn = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int lows;
        press(4'd1); press(4'd2); press(4'd3); press(4'd0);
        total++;
        if (digits !== 16'h1230 || digit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL load_entry: digits=%h cnt=%0d want 1230 cnt 4", digits, digit_cnt);
        end
        exp_q.push_back(16'h1230);
        pulse_start();
        total++;
        if (loadn !== 1'b1 || dbg_state !== S_LOAD) begin
            bad++;
            $display("FAIL load_setup: loadn=%b st=%0d want 1 st %0d", loadn, dbg_state, S_LOAD);
        end
        lows = 0;
        tick();
        while (loadn === 1'b0 && lows < 10) begin
            lows++;
            tick();
        end
        total++;
        if (lows != LC || armed !== 1'b1) begin
            bad++;
            $display("FAIL load_width: low=%0d armed=%b want %0d armed 1", lows, armed, LC);
        end
        pulse_clear();
        total++;
        if (digits !== 16'h0000 || dbg_state !== S_IDLE || armed !== 1'b0) begin
            bad++;
            $display("FAIL armed_clear: digits=%h st=%0d armed=%b", digits, dbg_state, armed);
        end
    endtask

    task automatic test_shift_invalid();
        for (int k = 1; k <= 5; k++) press(4'(k));
        total++;
        if (digits !== 16'h2345 || digit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL shift: digits=%h cnt=%0d want 2345 cnt 4", digits, digit_cnt);
        end
        press(4'd12);
        total++;
        if (err !== 1'b1 || digits !== 16'h2345) begin
            bad++;
            $display("FAIL invalid_key: err=%b digits=%h want 1 2345", err, digits);
        end
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_one_shot: err=%b want 0", err);
        end
        pulse_clear();
        total++;
        if (digits !== 16'h0000 || digit_cnt !== 3'd0 || dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL entry_clear: digits=%h cnt=%0d st=%0d", digits, digit_cnt, dbg_state);
        end
    endtask

    task automatic test_normalize();
        press(4'd9); press(4'd0);
`ifdef TIMER_ENTRY_NORMALIZE_EN
        exp_q.push_back(16'h0130);
        pulse_start();
        total++;
        if (digits !== 16'h0130 || dbg_state !== S_LOAD) begin
            bad++;
            $display("FAIL normalize: digits=%h st=%0d want 0130 LOAD", digits, dbg_state);
        end
        wait_armed("normalize");
        pulse_clear();
        for (int i = 0; i < 4; i++) press(4'd9);
        exp_q.push_back(16'h9959);
        pulse_start();
        total++;
        if (digits !== 16'h9959) begin
            bad++;
            $display("FAIL clamp: digits=%h want 9959", digits);
        end
        wait_armed("clamp");
`else
        pulse_start();
        total++;
        if (err !== 1'b1 || digits !== 16'h0090 || dbg_state !== S_ENTRY || loadn !== 1'b1) begin
            bad++;
            $display("FAIL sec_reject: err=%b digits=%h st=%0d loadn=%b", err, digits, dbg_state, loadn);
        end
        repeat (3) tick();
        total++;
        if (loadn !== 1'b1 || dbg_state !== S_ENTRY) begin
            bad++;
            $display("FAIL sec_reject_noload: loadn=%b st=%0d", loadn, dbg_state);
        end
`endif
        pulse_clear();
    endtask

    task automatic test_locked();
        press(4'd4); press(4'd5);
        exp_q.push_back(16'h0045);
        pulse_start();
        wait_armed("locked");
        run_busy = 1'b1;
        tick();
        total++;
        if (dbg_state !== S_LOCKED || armed !== 1'b0) begin
            bad++;
            $display("FAIL lock_enter: st=%0d armed=%b", dbg_state, armed);
        end
        press(4'd7);
        pulse_start();
        pulse_clear();
        total++;
        if (digits !== 16'h0045 || digit_cnt !== 3'd2 || dbg_state !== S_LOCKED || loadn !== 1'b1) begin
            bad++;
            $display("FAIL lock_ignore: digits=%h cnt=%0d st=%0d loadn=%b", digits, digit_cnt, dbg_state, loadn);
        end
        run_busy = 1'b0;
        tick();
        total++;
        if (digits !== 16'h0000 || digit_cnt !== 3'd0 || dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL run_end: digits=%h cnt=%0d st=%0d", digits, digit_cnt, dbg_state);
        end
    endtask

    task automatic test_priority();
        press(4'd3);
        key_valid = 1'b1; key_code = 4'd5; start = 1'b1; clear_entry = 1'b1;
        tick();
        key_valid = 1'b0; start = 1'b0; clear_entry = 1'b0;
        total++;
        if (digits !== 16'h0000 || dbg_state !== S_IDLE || loadn !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL priority: digits=%h st=%0d loadn=%b err=%b", digits, dbg_state, loadn, err);
        end
        tick();
        total++;
        if (loadn !== 1'b1 || dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL priority_noload: loadn=%b st=%0d", loadn, dbg_state);
        end
    endtask

    task automatic test_reset_in_load();
        press(4'd1);
        exp_q.push_back(16'h0001);
        pulse_start();
        tick();
        clrn = 1'b0;
        tick();
        total++;
        if (loadn !== 1'b1 || dbg_state !== S_IDLE || digits !== 16'h0000) begin
            bad++;
            $display("FAIL reset_in_load: loadn=%b st=%0d digits=%h", loadn, dbg_state, digits);
        end
        clrn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_invalid();
        test_normalize();
        test_locked();
        test_priority();
        test_reset_in_load();
        repeat (2) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL loads_missing: %0d expected loads never seen", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
